// File: rtl/dmem_dump_unit_pkg.sv
// Shared defaults, FSM state encoding and helpers for the data-memory dump unit.
package dmem_dump_unit_pkg;

  localparam int DUMP_BASE_ADDR   = 96;
  localparam int DUMP_NUM_WORDS   = 32;
  localparam int DUMP_HALT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

  function automatic logic is_busy(dump_state_e s);
    return (s == ST_RD) || (s == ST_WAIT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/dmem_dump_unit_if.sv
// Memory read port plus valid/ready dump stream between the dump unit and its neighbours.
interface dmem_dump_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) ();

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic                  dump_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output dump_valid, dump_data, dump_addr, dump_last,
    input  dump_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  dump_valid, dump_data, dump_addr, dump_last,
    output dump_ready
  );

endinterface

// File: rtl/dmem_dump_unit_pc_halt_detector.sv
// Declares a CPU halt once the PC has compared equal to its previous value for
// HALT_CYCLES-1 counted cycles plus the current one; frozen while i_en is low.
module pc_halt_detector
  import dmem_dump_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_CYCLES = DUMP_HALT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_halt
);

  localparam int            CW      = $clog2(HALT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALT_CYCLES - 1);

  logic [PC_WIDTH-1:0] r_prev_pc;
  logic [CW-1:0]       r_stable_cnt;
  logic                w_same;

  assign w_same = (i_pc == r_prev_pc);
  assign o_halt = i_en && w_same && (r_stable_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_pc    <= '0;
      r_stable_cnt <= '0;
    end else if (i_en) begin
      r_prev_pc <= i_pc;
      if (!w_same)
        r_stable_cnt <= '0;
      else if (r_stable_cnt != CNT_MAX)
        r_stable_cnt <= r_stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_dump_unit.sv
// Post-run extractor: on halt or force_dump, reads a fixed window of data memory
// (1-cycle read latency) and streams each word out over valid/ready.
module dmem_dump_unit
  import dmem_dump_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int BASE_ADDR   = DUMP_BASE_ADDR,
  parameter int NUM_WORDS   = DUMP_NUM_WORDS,
  parameter int HALT_CYCLES = DUMP_HALT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] ext_pc,
  input  logic                force_dump,
  dmem_dump_unit_if.master    bus,
  output logic                busy,
  output logic                done
);

  // One extra index bit so the counter never wraps on the final word.
  localparam int            IW       = $clog2(NUM_WORDS) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  dump_state_e r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic w_halt, w_start, w_hs;

  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  pc_halt_detector #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == ST_IDLE),
    .i_pc   (ext_pc),
    .o_halt (w_halt)
  );

  assign w_start = (r_state == ST_IDLE) && (w_halt || force_dump);
  assign w_hs    = (r_state == ST_HOLD) && bus.dump_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: if (w_start) begin
        w_state_nxt = ST_RD;
        w_idx_nxt   = '0;
      end
      ST_RD:   w_state_nxt = ST_WAIT;
      ST_WAIT: w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_hs) begin
        if (r_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RD;
          w_idx_nxt   = r_idx + IW'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_addr    <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en <= (w_state_nxt == ST_RD);
      r_busy  <= is_busy(w_state_nxt);
      if (w_state_nxt == ST_RD)
        r_rd_addr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(w_idx_nxt);
      if (r_state == ST_WAIT) begin
        r_data  <= bus.mem_rd_data;
        r_addr  <= r_rd_addr;
        r_last  <= (r_idx == LAST_IDX);
        r_valid <= 1'b1;
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        if (r_last)
          r_done <= 1'b1;
      end
    end
  end

  assign bus.mem_rd_en   = r_rd_en;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.dump_valid  = r_valid;
  assign bus.dump_data   = r_data;
  assign bus.dump_addr   = r_addr;
  assign bus.dump_last   = r_last;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
